// File: rtl/line_cut_position_scheduler_pkg.sv
// Shared video-crypto definitions for the line-rotation cut scheduler
// and its descrambler counterpart.
package line_cut_position_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        SCALE,
        PEND
    } state_t;

    localparam int LINE_GROUPS   = 360;
    localparam int GROUP_SAMPLES = 4;
    localparam int SCALE_NUM     = 11;
    localparam int SCALE_FRAC    = 3;
    localparam int OFFSET_GROUPS = 4;
    localparam int GUARD_GROUPS  = 2;
    localparam int LINE_SAMPLES  = LINE_GROUPS * GROUP_SAMPLES;

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/line_cut_position_scheduler_cut_group_scaler.sv
// Pure scale+offset+clamp: registered product to cut group index.
// Shared between scrambler and descrambler paths.
module cut_group_scaler #(
    parameter int PROD_W        = 13,
    parameter int POS_W         = 11,
    parameter int SCALE_FRAC    = 3,
    parameter int OFFSET_GROUPS = 4,
    parameter int MAX_GROUP     = 358
) (
    input  logic [PROD_W-1:0] prod,
    output logic [POS_W-1:0]  group,
    output logic              clamped
);

    localparam int SUM_W = ((PROD_W > POS_W) ? PROD_W : POS_W) + 1;
    localparam logic [SUM_W-1:0] MAX_G = SUM_W'(MAX_GROUP);
    localparam logic [SUM_W-1:0] OFS_G = SUM_W'(OFFSET_GROUPS);

    logic [SUM_W-1:0] sum;

    assign sum = SUM_W'(prod >> SCALE_FRAC) + OFS_G;

    always_comb begin
        clamped = 1'b0;
        group   = sum[POS_W-1:0];
        if (sum > MAX_G) begin
            clamped = 1'b1;
            group   = POS_W'(MAX_GROUP);
        end
    end

endmodule

// File: rtl/line_cut_position_scheduler.sv
// Registered cut-position scheduler: scales a PRNG seed to a group-aligned
// cut and commits it atomically on the line-start strobe.
module line_cut_position_scheduler
    import line_cut_position_scheduler_pkg::*;
#(
    parameter int RAW_W         = 8,
    parameter int POS_W         = 11,
    parameter int SCALE_NUM     = line_cut_position_scheduler_pkg::SCALE_NUM,
    parameter int SCALE_FRAC    = line_cut_position_scheduler_pkg::SCALE_FRAC,
    parameter int OFFSET_GROUPS = line_cut_position_scheduler_pkg::OFFSET_GROUPS,
    parameter int GROUP_SAMPLES = line_cut_position_scheduler_pkg::GROUP_SAMPLES,
    parameter int LINE_GROUPS   = line_cut_position_scheduler_pkg::LINE_GROUPS,
    parameter int GUARD_GROUPS  = line_cut_position_scheduler_pkg::GUARD_GROUPS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             raw_valid,
    output logic             raw_ready,
    input  logic [RAW_W-1:0] raw_cut,
    input  logic             line_start,
    input  logic             enable,
    output logic [POS_W-1:0] cut_position,
    output logic [POS_W-1:0] tail_length,
    output logic             cut_apply,
    output logic             clamped,
    output logic [7:0]       underrun_cnt
);

    localparam int PROD_W    = RAW_W + $clog2(SCALE_NUM) + 1;
    localparam int MAX_GROUP = LINE_GROUPS - GUARD_GROUPS;
    localparam int LINE_SMP  = LINE_GROUPS * GROUP_SAMPLES;
    localparam int GS_SHIFT  = $clog2(GROUP_SAMPLES);
    localparam logic [POS_W-1:0] FULL_LINE = POS_W'(LINE_SMP);

    if (LINE_SMP >= (1 << POS_W)) begin : g_pos_w_chk
        $error("POS_W too narrow for a full line of samples");
    end
    if (OFFSET_GROUPS > MAX_GROUP) begin : g_offset_chk
        $error("OFFSET_GROUPS exceeds the last legal cut group");
    end

    state_t state;
    state_t state_next;

    logic [RAW_W-1:0]  raw_r;
    logic [PROD_W-1:0] prod_r;
    logic [POS_W-1:0]  pend_cut;
    logic [POS_W-1:0]  pend_tail;
    logic              pend_clamped;

    logic [POS_W-1:0]  grp;
    logic              grp_clamped;
    logic [POS_W-1:0]  cut_next;

    cut_group_scaler #(
        .PROD_W        (PROD_W),
        .POS_W         (POS_W),
        .SCALE_FRAC    (SCALE_FRAC),
        .OFFSET_GROUPS (OFFSET_GROUPS),
        .MAX_GROUP     (MAX_GROUP)
    ) u_scaler (
        .prod    (prod_r),
        .group   (grp),
        .clamped (grp_clamped)
    );

    if (is_pow2(GROUP_SAMPLES)) begin : g_gs_shift
        assign cut_next = grp << GS_SHIFT;
    end else begin : g_gs_mul
        assign cut_next = grp * POS_W'(GROUP_SAMPLES);
    end

    always_comb begin
        state_next = state;
        raw_ready  = 1'b0;
        unique case (state)
            IDLE: begin
                raw_ready = 1'b1;
                if (raw_valid) state_next = MUL;
            end
            MUL:   state_next = SCALE;
            SCALE: state_next = PEND;
            PEND: begin
                if (line_start && enable) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raw_r        <= '0;
            prod_r       <= '0;
            pend_cut     <= '0;
            pend_tail    <= '0;
            pend_clamped <= 1'b0;
        end else begin
            if (state == IDLE && raw_valid) raw_r <= raw_cut;
            if (state == MUL) prod_r <= PROD_W'(raw_r) * PROD_W'(SCALE_NUM);
            if (state == SCALE) begin
                pend_cut     <= cut_next;
                pend_tail    <= FULL_LINE - cut_next;
                pend_clamped <= grp_clamped;
            end
        end
    end

    // Outputs only move on line_start so the cut is stable across the line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cut_position <= '0;
            tail_length  <= FULL_LINE;
            cut_apply    <= 1'b0;
            clamped      <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            cut_apply <= line_start;
            if (line_start) begin
                if (!enable) begin
                    cut_position <= '0;
                    tail_length  <= FULL_LINE;
                    clamped      <= 1'b0;
                end else if (state == PEND) begin
                    cut_position <= pend_cut;
                    tail_length  <= pend_tail;
                    clamped      <= pend_clamped;
                end else if (underrun_cnt != 8'hFF) begin
                    underrun_cnt <= underrun_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_line_cut_position_scheduler.sv
// Directed bench: default build plus a SCALE_NUM=12 build sharing stimulus.
module tb_line_cut_position_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        raw_valid = 1'b0;
    logic [7:0]  raw_cut = '0;
    logic        line_start = 1'b0;
    logic        enable = 1'b0;

    logic        raw_ready, raw_ready2;
    logic [10:0] cut_position, cut_position2;
    logic [10:0] tail_length, tail_length2;
    logic        cut_apply, cut_apply2;
    logic        clamped, clamped2;
    logic [7:0]  underrun_cnt, underrun_cnt2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    line_cut_position_scheduler dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .raw_valid    (raw_valid),
        .raw_ready    (raw_ready),
        .raw_cut      (raw_cut),
        .line_start   (line_start),
        .enable       (enable),
        .cut_position (cut_position),
        .tail_length  (tail_length),
        .cut_apply    (cut_apply),
        .clamped      (clamped),
        .underrun_cnt (underrun_cnt)
    );

    line_cut_position_scheduler #(.SCALE_NUM(12)) dut12 (
        .clk          (clk),
        .rst_n        (rst_n),
        .raw_valid    (raw_valid),
        .raw_ready    (raw_ready2),
        .raw_cut      (raw_cut),
        .line_start   (line_start),
        .enable       (enable),
        .cut_position (cut_position2),
        .tail_length  (tail_length2),
        .cut_apply    (cut_apply2),
        .clamped      (clamped2),
        .underrun_cnt (underrun_cnt2)
    );

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_raw(input logic [7:0] v);
        raw_valid = 1'b1;
        raw_cut   = v;
        cyc();
        raw_valid = 1'b0;
        cyc(3);
    endtask

    task automatic strobe(input logic en);
        line_start = 1'b1;
        enable     = en;
        cyc();
        line_start = 1'b0;
    endtask

    task automatic chk_out(input string nm, input logic [10:0] c,
                           input logic [10:0] t, input logic cl);
        checks++;
        if (cut_position !== c || tail_length !== t || clamped !== cl) begin
            failures++;
            $display("FAIL %s got cut=%0d tail=%0d clamp=%0b want cut=%0d tail=%0d clamp=%0b",
                     nm, cut_position, tail_length, clamped, c, t, cl);
        end
    endtask

    task automatic test_reset();
        cyc(3);
        checks++;
        if (raw_ready !== 1'b1 || cut_apply !== 1'b0 || underrun_cnt !== 8'd0) begin
            failures++;
            $display("FAIL reset_ctl got ready=%0b apply=%0b und=%0d want 1 0 0",
                     raw_ready, cut_apply, underrun_cnt);
        end
        chk_out("reset_out", 11'd0, 11'd1440, 1'b0);
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_basic_zero();
        send_raw(8'd0);
        checks++;
        if (raw_ready !== 1'b0) begin
            failures++;
            $display("FAIL busy_ready got %0b want 0", raw_ready);
        end
        strobe(1'b1);
        checks++;
        if (cut_apply !== 1'b1) begin
            failures++;
            $display("FAIL apply_pulse got %0b want 1", cut_apply);
        end
        chk_out("raw0", 11'd16, 11'd1424, 1'b0);
        cyc();
        checks++;
        if (cut_apply !== 1'b0 || raw_ready !== 1'b1) begin
            failures++;
            $display("FAIL apply_end got apply=%0b ready=%0b want 0 1",
                     cut_apply, raw_ready);
        end
    endtask

    task automatic test_scaling();
        send_raw(8'd100);
        strobe(1'b1);
        chk_out("raw100", 11'd564, 11'd876, 1'b0);
        cyc();
        send_raw(8'd255);
        strobe(1'b1);
        chk_out("raw255", 11'd1416, 11'd24, 1'b0);
        checks++;
        if (cut_position2 !== 11'd1432 || tail_length2 !== 11'd8 || clamped2 !== 1'b1) begin
            failures++;
            $display("FAIL clamp12 got cut=%0d tail=%0d clamp=%0b want 1432 8 1",
                     cut_position2, tail_length2, clamped2);
        end
        cyc();
    endtask

    task automatic test_underrun();
        for (int i = 0; i < 3; i++) begin
            strobe(1'b1);
            cyc();
        end
        checks++;
        if (underrun_cnt !== 8'd3) begin
            failures++;
            $display("FAIL underrun3 got %0d want 3", underrun_cnt);
        end
        chk_out("underrun_hold", 11'd1416, 11'd24, 1'b0);
        for (int i = 0; i < 300; i++) begin
            strobe(1'b1);
            cyc();
        end
        checks++;
        if (underrun_cnt !== 8'd255) begin
            failures++;
            $display("FAIL underrun_sat got %0d want 255", underrun_cnt);
        end
    endtask

    task automatic test_disable_retain();
        send_raw(8'd100);
        strobe(1'b0);
        chk_out("disabled", 11'd0, 11'd1440, 1'b0);
        checks++;
        if (raw_ready !== 1'b0 || cut_apply !== 1'b1) begin
            failures++;
            $display("FAIL retain got ready=%0b apply=%0b want 0 1",
                     raw_ready, cut_apply);
        end
        cyc();
        strobe(1'b1);
        chk_out("retained_commit", 11'd564, 11'd876, 1'b0);
        cyc();
    endtask

    task automatic test_reset_in_scale();
        raw_valid = 1'b1;
        raw_cut   = 8'd255;
        cyc();
        raw_valid = 1'b0;
        cyc();
        rst_n = 1'b0;
        #1;
        chk_out("async_rst_out", 11'd0, 11'd1440, 1'b0);
        checks++;
        if (raw_ready !== 1'b1 || underrun_cnt !== 8'd0) begin
            failures++;
            $display("FAIL async_rst_ctl got ready=%0b und=%0d want 1 0",
                     raw_ready, underrun_cnt);
        end
        #2;
        rst_n = 1'b1;
        cyc();
        strobe(1'b1);
        chk_out("no_commit", 11'd0, 11'd1440, 1'b0);
        checks++;
        if (underrun_cnt !== 8'd1) begin
            failures++;
            $display("FAIL post_rst_underrun got %0d want 1", underrun_cnt);
        end
        cyc();
    endtask

    task automatic test_back_to_back();
        raw_valid  = 1'b1;
        raw_cut    = 8'd100;
        line_start = 1'b1;
        enable     = 1'b1;
        cyc();
        raw_valid  = 1'b0;
        line_start = 1'b0;
        checks++;
        if (underrun_cnt !== 8'd2 || raw_ready !== 1'b0) begin
            failures++;
            $display("FAIL hs_and_ls got und=%0d ready=%0b want 2 0",
                     underrun_cnt, raw_ready);
        end
        cyc(3);
        strobe(1'b1);
        chk_out("hs_ls_commit", 11'd564, 11'd876, 1'b0);
        cyc();
    endtask

    initial begin
        test_reset();
        test_basic_zero();
        test_scaling();
        test_underrun();
        test_disable_retain();
        test_reset_in_scale();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/line_cut_position_scheduler.md
Name: line_cut_position_scheduler

Overview:
Parametrised, registered successor of the combinational cut-position mapper used by the line-rotation scrambler.
- Accepts random raw values over a valid/ready handshake.
- Scales each value to a group-aligned cut position in a multi-cycle datapath. A group is one CrYCbY quad, so a cut never splits a group.
- Adds clamping and a complementary tail length.
- Holds the result pending and commits it atomically on the line-start strobe, so the cut stays stable for a whole active line.
- Sits between the PRNG and the line-rotation buffer.

Parameters:
RAW_W, 8, width of raw random input
POS_W, 11, width of cut_position and tail_length
SCALE_NUM, 11, fixed-point scale numerator (11/8 = 1.375)
SCALE_FRAC, 3, fractional bits of scale (right shift)
OFFSET_GROUPS, 4, groups skipped at line start
GROUP_SAMPLES, 4, samples per CrYCbY group
LINE_GROUPS, 360, groups per active line
GUARD_GROUPS, 2, groups reserved at line end (max cut group = LINE_GROUPS-GUARD_GROUPS)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
raw_valid  in  1  raw_cut valid
raw_ready  out  1  block can accept raw_cut
raw_cut  in  RAW_W  random cut seed
line_start  in  1  one-cycle strobe at start of each active line
enable  in  1  scrambling enable, sampled at line_start
cut_position  out  POS_W  committed cut, in samples
tail_length  out  POS_W  LINE_GROUPS*GROUP_SAMPLES - cut_position
cut_apply  out  1  one-cycle pulse, cycle after line_start
clamped  out  1  committed cut was clamped
underrun_cnt  out  8  saturating count of line_starts with no pending cut while enabled

Behaviour:
- Reset (async, any time including mid-computation): state IDLE, all registers cleared.
  - Reset output values: raw_ready=1, cut_position=0, tail_length=LINE_GROUPS*GROUP_SAMPLES, cut_apply=0, clamped=0, underrun_cnt=0.
- FSM states: IDLE, MUL, SCALE, PEND.
  - raw_ready = (state==IDLE).
  - IDLE: when raw_valid && raw_ready, register raw_cut, then go to MUL.
  - MUL: register prod = raw*SCALE_NUM (width RAW_W+clog2(SCALE_NUM)+1, no overflow), then go to SCALE.
  - SCALE: g = (prod>>SCALE_FRAC)+OFFSET_GROUPS. If g > LINE_GROUPS-GUARD_GROUPS, set g to that value and pend_clamped=1. Pending cut = g*GROUP_SAMPLES. Go to PEND.
  - PEND: wait for line_start.
- Latency: handshake in cycle 0; pending result valid in PEND from cycle 3.
- Commit on line_start (any state); all outputs update on the next edge, with cut_apply=1 for one cycle:
  - enable=1 and state==PEND: outputs take pending cut, tail and clamp flag; state goes to IDLE.
  - enable=1 and state!=PEND: outputs unchanged (repeat previous cut); underrun_cnt+1, saturating at 255. An in-flight computation continues.
  - enable=0: cut_position=0, tail_length=full line, clamped=0; a pending value is retained, not consumed; no underrun counted.
- Same cycle as the IDLE handshake plus line_start: the handshake is accepted and the line_start counts as an underrun.
- Arithmetic is unsigned throughout; the multiply by GROUP_SAMPLES is a shift when GROUP_SAMPLES is a power of two.
- Elaboration check: POS_W must hold LINE_GROUPS*GROUP_SAMPLES, and OFFSET_GROUPS must be <= LINE_GROUPS-GUARD_GROUPS.

Decomposition:
- Shared video-crypto package:
  - state enum (IDLE/MUL/SCALE/PEND);
  - default constants LINE_GROUPS=360, GROUP_SAMPLES=4, SCALE_NUM=11, SCALE_FRAC=3, OFFSET_GROUPS=4;
  - derived LINE_SAMPLES=1440.
- One sub-module, cut_group_scaler: the pure scale+offset+clamp datapath from registered prod to (group, clamped), instantiated in the SCALE stage and reusable by the descrambler.

Test Plan:
- Reset, then raw_cut=0 accepted, then line_start with enable=1: cut_position=16, tail_length=1424, clamped=0, cut_apply pulses one cycle after line_start.
- raw_cut=100 → cut_position=564, tail_length=876.
- raw_cut=255 → cut_position=1416, tail_length=24, clamped=0.
- Override SCALE_NUM=12, raw_cut=255 → g clamps to 358; cut_position=1432, tail_length=8, clamped=1.
- Three line_starts with no raw_valid while enable=1: outputs hold the last cut and underrun_cnt=3. After 300 more, underrun_cnt stays at 255.
- Pending value present and line_start with enable=0: cut_position=0, tail=1440. Next line_start with enable=1 commits the retained value.
- rst_n low while state==SCALE: outputs return to reset values immediately, raw_ready=1, and no commit occurs on the following line_start.
